// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// coin encodings, coin values, FSM states and the cents datapath width.
package vend_pkg;

  localparam int CENTS_W = 9;

  localparam logic [4:0] COIN_NICKEL  = 5'b00001;
  localparam logic [4:0] COIN_DIME    = 5'b00010;
  localparam logic [4:0] COIN_QUARTER = 5'b00100;
  localparam logic [4:0] COIN_HALF    = 5'b01000;
  localparam logic [4:0] COIN_DOLLAR  = 5'b10000;

  localparam logic [CENTS_W-1:0] VAL_NICKEL  = 9'd5;
  localparam logic [CENTS_W-1:0] VAL_DIME    = 9'd10;
  localparam logic [CENTS_W-1:0] VAL_QUARTER = 9'd25;
  localparam logic [CENTS_W-1:0] VAL_HALF    = 9'd50;
  localparam logic [CENTS_W-1:0] VAL_DOLLAR  = 9'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHG_START,
    ST_CHG_WAIT
  } state_t;

  // Non-one-hot patterns map to zero; callers reject them separately.
  function automatic logic [CENTS_W-1:0] coin_value(input logic [4:0] coin);
    logic [CENTS_W-1:0] v;
    v = '0;
    case (coin)
      COIN_NICKEL:  v = VAL_NICKEL;
      COIN_DIME:    v = VAL_DIME;
      COIN_QUARTER: v = VAL_QUARTER;
      COIN_HALF:    v = VAL_HALF;
      COIN_DOLLAR:  v = VAL_DOLLAR;
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle down-counter: reloads on clear, counts enabled cycles and flags
// expire on the LIMIT-th consecutive enabled, uncleared cycle.
module vend_idle_timer #(
  parameter int           W     = 24,
  parameter logic [W-1:0] LIMIT = W'(16)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= LIMIT - W'(1);
    end else if (enable && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = enable && !clear && (count == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit accumulation, selection, vend pulse
// and change-maker handshake. VEND_SEQ_TIMEOUT_EN adds an idle auto-refund.
//
// state        | meaning
// ST_IDLE      | no credit, accepting coins
// ST_CREDIT    | credit > 0, accepting coins, selections, refund
// ST_VEND      | one-cycle dispense pulse
// ST_CHG_START | one cycle before waiting on the change maker
// ST_CHG_WAIT  | waiting for cm_done
module vend_sequencer
  import vend_pkg::*;
#(
  parameter logic [8:0]  PRICE0      = 9'd65,
  parameter logic [8:0]  PRICE1      = 9'd100,
  parameter logic [8:0]  PRICE2      = 9'd125,
  parameter logic [8:0]  PRICE3      = 9'd150,
  parameter logic [8:0]  MAX_CREDIT  = 9'd300,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         coin_in,
  input  logic               sel_valid,
  input  logic [1:0]         sel_id,
  input  logic               refund_req,
  input  logic               cm_done,
  output logic               cm_start,
  output logic [CENTS_W-1:0] cm_change,
  output logic               vend,
  output logic [1:0]         vend_id,
  output logic               coin_reject,
  output logic               sel_denied,
  output logic [CENTS_W-1:0] credit,
  output logic               busy
);

  state_t             state;
  logic               refund_path;
  logic [CENTS_W-1:0] price;
  logic [CENTS_W:0]   coin_sum;
  logic               accepting;
  logic               coin_accept;
  logic               auto_refund;
  logic               do_refund;

  always_comb begin
    price = PRICE0;
    case (sel_id)
      2'd0: price = PRICE0;
      2'd1: price = PRICE1;
      2'd2: price = PRICE2;
      2'd3: price = PRICE3;
      default: price = PRICE0;
    endcase
  end

  assign accepting   = (state == ST_IDLE) || (state == ST_CREDIT);
  assign coin_sum    = {1'b0, credit} + {1'b0, coin_value(coin_in)};
  // Refund and selection outrank a coin in the same cycle, so the coin goes back.
  assign coin_accept = accepting && $onehot(coin_in) && !sel_valid && !refund_req
                       && (coin_sum <= {1'b0, MAX_CREDIT});

`ifdef VEND_SEQ_TIMEOUT_EN
  logic timer_clear;

  assign timer_clear = (state != ST_CREDIT) || (coin_in != 5'd0) || sel_valid || refund_req;

  vend_idle_timer #(
    .W     (24),
    .LIMIT (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state == ST_CREDIT),
    .expire (auto_refund)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYC;
  assign auto_refund    = 1'b0;
`endif

  assign do_refund = (refund_req || auto_refund) && (state == ST_CREDIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      credit      <= '0;
      cm_change   <= '0;
      vend_id     <= 2'd0;
      refund_path <= 1'b0;
      cm_start    <= 1'b0;
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      sel_denied  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cm_start    <= 1'b0;
      vend        <= 1'b0;
      sel_denied  <= 1'b0;
      coin_reject <= (coin_in != 5'd0) && !coin_accept;

      case (state)
        ST_IDLE, ST_CREDIT: begin
          if (do_refund) begin
            cm_change   <= credit;
            credit      <= '0;
            refund_path <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_CHG_START;
          end else if (sel_valid) begin
            if (credit >= price) begin
              cm_change   <= credit - price;
              credit      <= '0;
              vend        <= 1'b1;
              vend_id     <= sel_id;
              refund_path <= 1'b0;
              busy        <= 1'b1;
              state       <= ST_VEND;
            end else begin
              sel_denied <= 1'b1;
            end
          end else if (coin_accept) begin
            credit <= coin_sum[CENTS_W-1:0];
            state  <= ST_CREDIT;
          end
        end

        ST_VEND: begin
          if (cm_change != '0) begin
            cm_start <= 1'b1;
            state    <= ST_CHG_START;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        // A refund enters here without a start pulse yet; it fires now so that
        // start lands two cycles after the request.
        ST_CHG_START: begin
          cm_start <= refund_path;
          state    <= ST_CHG_WAIT;
        end

        ST_CHG_WAIT: begin
          if (cm_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized and directed checking of vend_sequencer against a
// transaction-level reference model of credit, vend and change timing.
module tb_vend_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] coin_in;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       refund_req;
  logic       cm_done;
  logic       cm_start;
  logic [8:0] cm_change;
  logic       vend;
  logic [1:0] vend_id;
  logic       coin_reject;
  logic       sel_denied;
  logic [8:0] credit;
  logic       busy;

  always #5 clk = ~clk;

  vend_sequencer #(.TIMEOUT_CYC(24'(TO))) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_in     (coin_in),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .refund_req  (refund_req),
    .cm_done     (cm_done),
    .cm_start    (cm_start),
    .cm_change   (cm_change),
    .vend        (vend),
    .vend_id     (vend_id),
    .coin_reject (coin_reject),
    .sel_denied  (sel_denied),
    .credit      (credit),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  int price_tbl[4] = '{65, 100, 125, 150};
  int coin_vals[5] = '{5, 10, 25, 50, 100};

  // reference model: a transaction is described by the absolute cycle numbers
  // at which its observable events are due
  int cyc;
  int m_credit, m_change, m_vend_id, idle_cnt;
  bit m_txn;
  int vend_cyc, start_cyc, wait_from, end_cyc;
  bit e_vend, e_start, e_rej, e_den;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int coin_sum_val(input logic [4:0] c);
    int v = 0;
    for (int i = 0; i < 5; i++) if (c[i]) v += coin_vals[i];
    return v;
  endfunction

  task automatic model_reset();
    m_credit  = 0;
    m_change  = 0;
    m_vend_id = 0;
    m_txn     = 0;
    idle_cnt  = 0;
    vend_cyc  = -1;
    start_cyc = -1;
    wait_from = -1;
    end_cyc   = -1;
  endtask

  task automatic step(input logic [4:0] c, input bit s, input logic [1:0] id,
                      input bit r, input bit d, input bit rst);
    bit to;
    reset      = rst;
    coin_in    = c;
    sel_valid  = s;
    sel_id     = id;
    refund_req = r;
    cm_done    = d;
    e_vend = 0; e_rej = 0; e_den = 0; to = 0;

    if (rst) begin
      model_reset();
    end else if (!m_txn) begin
`ifdef VEND_SEQ_TIMEOUT_EN
      if (m_credit > 0 && c == 5'd0 && !s && !r) begin
        idle_cnt++;
        if (idle_cnt == TO) to = 1;
      end else begin
        idle_cnt = 0;
      end
`endif
      if ((r || to) && m_credit > 0) begin
        m_change  = m_credit;
        m_credit  = 0;
        m_txn     = 1;
        start_cyc = cyc + 2;
        wait_from = cyc + 2;
        end_cyc   = -1;
        idle_cnt  = 0;
      end else if (s) begin
        if (m_credit >= price_tbl[id]) begin
          m_change  = m_credit - price_tbl[id];
          m_credit  = 0;
          m_vend_id = id;
          e_vend    = 1;
          m_txn     = 1;
          if (m_change > 0) begin
            start_cyc = cyc + 2;
            wait_from = cyc + 3;
            end_cyc   = -1;
          end else begin
            start_cyc = -1;
            wait_from = -1;
            end_cyc   = cyc + 1;
          end
        end else begin
          e_den = 1;
        end
      end
      if (c != 5'd0) begin
        if (s || r || $countones(c) != 1 || m_credit + coin_sum_val(c) > 300) e_rej = 1;
        else m_credit += coin_sum_val(c);
      end
    end else begin
      idle_cnt = 0;
      if (c != 5'd0) e_rej = 1;
      if (end_cyc == cyc) m_txn = 0;
      else if (wait_from >= 0 && cyc >= wait_from && d) m_txn = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
    e_start = (start_cyc == cyc);

    check_val("credit",      32'(credit),      32'(m_credit));
    check_val("busy",        32'(busy),        32'(m_txn));
    check_val("vend",        32'(vend),        32'(e_vend));
    check_val("cm_start",    32'(cm_start),    32'(e_start));
    check_val("coin_reject", 32'(coin_reject), 32'(e_rej));
    check_val("sel_denied",  32'(sel_denied),  32'(e_den));
    check_val("cm_change",   32'(cm_change),   32'(m_change));
    check_val("vend_id",     32'(vend_id),     32'(m_vend_id));
  endtask

  task automatic coin(input logic [4:0] c);
    step(c, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic done_pulse();
    step(5'd0, 0, 2'd0, 0, 1, 0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    step(5'd0, 0, 2'd0, 0, 0, 1);
    step(5'd0, 0, 2'd0, 0, 0, 1);

    // exact change: 65 for item 0, no change-maker cycle
    coin(5'b00100); coin(5'b00100); coin(5'b00010); coin(5'b00001);
    check_val("credit_65", 32'(credit), 32'd65);
    step(5'd0, 1, 2'd0, 0, 0, 0);
    idle(3);

    // 125 for item 0, 60 change, hold until done
    coin(5'b10000); coin(5'b00100);
    step(5'd0, 1, 2'd0, 0, 0, 0);
    idle(1);
    check_val("change_60", 32'(cm_change), 32'd60);
    idle(6);
    done_pulse();
    idle(1);

    // insufficient credit, then ceiling and multi-bit rejects
    coin(5'b01000);
    step(5'd0, 1, 2'd1, 0, 0, 0);
    coin(5'b10000); coin(5'b10000); coin(5'b00100);
    check_val("credit_275", 32'(credit), 32'd275);
    coin(5'b01000);
    coin(5'b00011);
    step(5'd0, 0, 2'd0, 1, 0, 0);
    idle(3);
    done_pulse();

    // refund with a simultaneous dime, then a coin during the wait
    coin(5'b00100); coin(5'b00010);
    step(5'b00010, 0, 2'd0, 1, 0, 0);
    check_val("refund_35", 32'(cm_change), 32'd35);
    idle(1);
    coin(5'b00010);
    idle(2);
    done_pulse();

    // credit held (or auto-refunded when the timeout is built in), then reset in the wait
    coin(5'b00010);
    idle(100);
`ifndef VEND_SEQ_TIMEOUT_EN
    check_val("credit_held", 32'(credit), 32'd10);
`endif
    step(5'd0, 0, 2'd0, 1, 0, 0);
    idle(3);
    step(5'd0, 0, 2'd0, 0, 0, 1);
    check_val("rst_credit", 32'(credit), 32'd0);
    check_val("rst_busy",   32'(busy),   32'd0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      logic [4:0] c;
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      c = 5'd0;
      else if (r < 92) c = 5'(1 << $urandom_range(0, 4));
      else             c = 5'($urandom_range(0, 31));
      step(c,
           $urandom_range(0, 99) < 10,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 999) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the vending machine. Accumulates inserted coins into a credit register, services item selections against a fixed price table, issues a one-cycle vend pulse, and sequences the change maker over its `start`/`done` handshake to return the remaining credit. It sits between the front-panel inputs and the change maker. The change maker's `change_in` and `start` are driven only by this block.

## Interface
Parameters:
- PRICE0, 9'd65: price in cents of item 0.
- PRICE1, 9'd100: price in cents of item 1.
- PRICE2, 9'd125: price in cents of item 2.
- PRICE3, 9'd150: price in cents of item 3.
- MAX_CREDIT, 9'd300: credit ceiling in cents.
- TIMEOUT_CYC, 24'd1_000_000: idle cycles before auto-refund (used only with VEND_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- coin_in  in  5  one-hot, one-cycle coin-accepted pulse. Bit 4 is a dollar, then half, quarter, dime; bit 0 is a nickel.
- sel_valid  in  1  one-cycle selection strobe.
- sel_id  in  2  item index; sampled only while sel_valid is high.
- refund_req  in  1  one-cycle coin-return button pulse.
- cm_done  in  1  change maker complete.
- cm_start  out  1  one-cycle start pulse to the change maker.
- cm_change  out  9  change amount; stable from the cm_start cycle until cm_done.
- vend  out  1  one-cycle dispense pulse.
- vend_id  out  2  item dispensed; valid while vend is high.
- coin_reject  out  1  one-cycle pulse; the coin is routed back to the customer.
- sel_denied  out  1  one-cycle pulse when credit is insufficient.
- credit  out  9  current credit in cents.
- busy  out  1  high in every state other than IDLE and CREDIT.

## Operation
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0.
  - VEND: a single cycle.
  - CHG_START: a single cycle.
  - CHG_WAIT: waits for cm_done.
- Coin handling in IDLE/CREDIT:
  - Exactly one bit of coin_in set, with credit + value <= MAX_CREDIT: the value is added and the state becomes CREDIT.
  - Multi-bit coin_in, or an addition that would exceed MAX_CREDIT: coin_reject pulses and credit is unchanged.
  - coin_in in any other state: coin_reject pulses.
- Selection in IDLE/CREDIT:
  - sel_valid with credit >= PRICE[sel_id]: go to VEND; cm_change <= credit - price; credit <= 0.
  - sel_valid with credit < price: sel_denied pulses and the state is unchanged.
  - sel_valid in any other state is ignored with no pulse.
- Simultaneous events in the same cycle, in priority order:
  1. refund_req
  2. sel_valid
  3. coin_in. A coin arriving with a selection or refund is rejected (coin_reject pulses) and not credited.
- refund_req in CREDIT: cm_change <= credit, credit <= 0, go to CHG_START. refund_req in IDLE is ignored.
- VEND: vend = 1 and vend_id = latched sel_id. Next state is CHG_START if cm_change != 0, otherwise IDLE.
- CHG_START: cm_start = 1; next state CHG_WAIT.
- CHG_WAIT: on cm_done, go to IDLE. cm_done in any other state is ignored.
- Arithmetic: 9-bit unsigned. The subtraction is performed only after the >= compare, so it never wraps.
- Reset values: state IDLE; credit, cm_change and vend_id are 0; all pulse outputs are 0; busy is 0.
- Reset mid-transaction returns to IDLE and discards credit. The change maker is reset by the same reset.

## Timing
- Coin credited: credit updates on the clock edge after the coin_in cycle. coin_reject is registered and asserts in the cycle after coin_in.
- Selection to vend: the cycle after the sel_valid cycle.
- Vend to cm_start: the next cycle. The following cycle is the first CHG_WAIT cycle.
- Refund: cm_start is two cycles after refund_req.
- All outputs are registered.
- Earliest acceptance of a new coin: the cycle after cm_done is seen.

## Configuration
- VEND_SEQ_TIMEOUT_EN defined:
  - In CREDIT, an idle counter counts cycles with no coin_in, sel_valid or refund_req.
  - At TIMEOUT_CYC it performs an auto-refund, identical to refund_req.
  - Any such input clears the counter; leaving CREDIT also clears it.
- Without the macro there is no counter and credit is held indefinitely.

## Structure
- Package vend_pkg: coin one-hot encodings, coin values (100/50/25/10/5), the state enum, and the CENTS_W = 9 width constant.
- Sub-module vend_idle_timer: the counter with clear, enable and expire. It is instantiated only under VEND_SEQ_TIMEOUT_EN.
- Price lookup: an inline mux on sel_id, not a separate module.

## Test plan
- Quarter, quarter, dime, nickel (credit 65), then select item 0: vend with vend_id = 0 one cycle after the selection; cm_start never asserts; credit = 0; returns to IDLE.
- Dollar then quarter (125), then select item 0: vend, then cm_start with cm_change = 60; the state holds CHG_WAIT until cm_done, then goes to IDLE.
- Credit 50, select item 1: sel_denied pulses; credit stays 50; state stays CREDIT.
- Credit 275, insert a half: coin_reject pulses; credit stays 275. Insert coin_in = 5'b00011: rejected.
- Credit 35 with refund_req and a dime on the same cycle: coin_reject pulses; cm_change = 35; cm_start pulses two cycles later. A coin during CHG_WAIT is rejected.
- With VEND_SEQ_TIMEOUT_EN and TIMEOUT_CYC = 16, credit 10, no input: auto-refund with cm_change = 10. Without the macro, credit stays 10 after 100 cycles. Reset asserted in CHG_WAIT returns to IDLE with credit 0.
